// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the multiplier arbiter and its round-robin picker.
package mul_arbiter_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned RW_DEF = 62;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RESP    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  // Index width for n requesters; never below one bit so vectors stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr_i, with wrap.
module mul_arbiter_rr_picker
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential multiplier between NREQ requesters with round-robin
// arbitration and a watchdog that resets the multiplier if finish never comes.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [RW-1:0]     rsp_res,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [DW-1:0]     mul_a,
  output logic [DW-1:0]     mul_b,
  output logic              mul_rst,
  input  logic [RW-1:0]     mul_res,
  input  logic              mul_finish,
  output logic              busy
);

  localparam int unsigned IW  = id_width(NREQ);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  id_q, id_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [RW-1:0]  res_q, res_d;
  logic           err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  mul_arbiter_rr_picker #(
    .N (NREQ)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    err_d     = err_q;
    wd_d      = wd_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_res   = '0;
    rsp_err   = 1'b0;
    mul_start = 1'b0;
    mul_rst   = 1'b0;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // The grant is combinational on req_valid, so it is also masked while
        // reset is held to keep every output quiet during reset.
        if (gnt_any && rst_n) begin
          req_ready = gnt;
          a_d       = req_a[gnt_idx*DW +: DW];
          b_d       = req_b[gnt_idx*DW +: DW];
          id_d      = gnt_idx;
          ptr_d     = gnt_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        wd_d      = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (mul_finish) begin
          res_d   = mul_res;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        mul_rst = 1'b1;
        res_d   = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        rsp_res         = res_q;
        rsp_err         = err_q;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mul_a = a_q;
  assign mul_b = b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed requests, behavioural multiplier,
// expected grants/responses queued at stimulus time and checked by a monitor.
module tb_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int RW      = 62;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 8;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [RW-1:0]      rsp_res;
  logic               rsp_err;
  logic               mul_start;
  logic [DW-1:0]      mul_a;
  logic [DW-1:0]      mul_b;
  logic               mul_rst;
  logic [RW-1:0]      mul_res;
  logic               mul_finish;
  logic               busy;

  mul_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .RW      (RW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_res    (rsp_res),
    .rsp_err    (rsp_err),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_rst    (mul_rst),
    .mul_res    (mul_res),
    .mul_finish (mul_finish),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned   id;
    logic [RW-1:0] res;
    logic          err;
  } rsp_t;

  rsp_t        exp_rsp[$];
  int unsigned exp_gnt[$];
  logic [2*DW-1:0] opq[NREQ][$];

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0, start_cyc = 0, fin_cyc = 0, rst_cyc = 0;
  int unsigned rst_pulses = 0;

  logic withhold = 1'b0, spur_issue = 1'b0, spur_idle_req = 1'b0, kill_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctl"}, 128'({req_ready, rsp_valid, rsp_err, mul_start, mul_rst, busy}), '0);
    check({name, "_res"}, 128'(rsp_res), '0);
    check({name, "_ops"}, 128'({mul_a, mul_b}), '0);
  endtask

  task automatic push_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
    opq[id].push_back({a, b});
  endtask

  task automatic expect_txn(input int id, input logic [RW-1:0] res, input logic err);
    rsp_t r;
    r.id  = id;
    r.res = res;
    r.err = err;
    exp_gnt.push_back(id);
    exp_rsp.push_back(r);
  endtask

  function automatic bit all_empty();
    bit e;
    e = (exp_gnt.size() == 0) && (exp_rsp.size() == 0);
    for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!all_empty() && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!all_empty()) begin
      failures++;
      $display("FAIL drain_%s: pending grants %0d responses %0d after %0d cycles, want 0",
               name, exp_gnt.size(), exp_rsp.size(), n);
    end
    repeat (2) @(negedge clk);
  endtask

  // Requester drivers: hold the head operand pair until it is seen accepted.
  initial begin
    logic [NREQ-1:0] acc;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && opq[i].size() > 0) void'(opq[i].pop_front());
        if (opq[i].size() > 0) begin
          req_valid[i]           = 1'b1;
          req_a[i*DW +: DW]      = opq[i][0][2*DW-1:DW];
          req_b[i*DW +: DW]      = opq[i][0][DW-1:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Behavioural multiplier: fixed latency, optional withheld or spurious finish.
  initial begin
    logic [DW-1:0] pa, pb;
    int  cnt;
    bit  active;
    active     = 1'b0;
    cnt        = 0;
    pa         = '0;
    pb         = '0;
    mul_finish = 1'b0;
    mul_res    = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_finish = 1'b0;
      if (kill_req) begin
        active   = 1'b0;
        kill_req = 1'b0;
      end
      if (mul_rst) active = 1'b0;
      if (spur_idle_req) begin
        mul_finish    = 1'b1;
        mul_res       = 62'h155;
        spur_idle_req = 1'b0;
      end
      if (mul_start) begin
        pa     = mul_a;
        pb     = mul_b;
        cnt    = LAT;
        active = 1'b1;
        if (spur_issue) begin
          mul_finish = 1'b1;
          mul_res    = '1;
        end
      end else if (active) begin
        cnt--;
        if (cnt == 0) begin
          active = 1'b0;
          if (!withhold) begin
            mul_finish = 1'b1;
            mul_res    = RW'({32'b0, pa} * {32'b0, pb});
            fin_cyc    = cyc;
          end
        end
      end
    end
  end

  // Monitor: compares grants, handshake timing and responses against the queues.
  initial begin
    logic [NREQ-1:0] onehot;
    rsp_t r;
    int unsigned g;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        acc_cyc = cyc;
        if (exp_gnt.size() == 0) begin
          check("unexpected_grant", 128'(req_ready), '0);
        end else begin
          g      = exp_gnt.pop_front();
          onehot = '0;
          onehot[g] = 1'b1;
          check("grant", 128'(req_ready), 128'(onehot));
        end
      end
      if (mul_start) begin
        start_cyc = cyc;
        check("start_latency", 128'(cyc - acc_cyc), 128'(1));
      end
      if (mul_rst) begin
        rst_cyc = cyc;
        rst_pulses++;
        check("timeout_cycle", 128'(cyc - start_cyc), 128'(TIMEOUT + 1));
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 128'(rsp_valid), '0);
        end else begin
          r      = exp_rsp.pop_front();
          onehot = '0;
          onehot[r.id] = 1'b1;
          check("rsp_owner", 128'(rsp_valid), 128'(onehot));
          check("rsp_res", 128'(rsp_res), 128'(r.res));
          check("rsp_err", 128'(rsp_err), 128'(r.err));
          if (r.err) check("rsp_after_rst", 128'(cyc - rst_cyc), 128'(1));
          else       check("rsp_after_fin", 128'(cyc - fin_cyc), 128'(1));
        end
      end
    end
  end

  task automatic pulse_reset(input string name);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    kill_req = 1'b1;
    #1;
    check_quiet(name);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request from requester 0.
    expect_txn(0, 62'd15, 1'b0);
    push_req(0, 32'd3, 32'd5);
    drain("single", 200);

    // All four requesters after a fresh reset: order 0,1,2,3,0.
    pulse_reset("reset2");
    repeat (2) @(negedge clk);
    expect_txn(0, 62'h1_FFFF_FFFE, 1'b0);
    expect_txn(1, 62'd42, 1'b0);
    expect_txn(2, 62'h1_0000_0000, 1'b0);
    expect_txn(3, 62'h123_4500, 1'b0);
    expect_txn(0, 62'd20000, 1'b0);
    push_req(0, 32'hFFFF_FFFF, 32'd2);
    push_req(0, 32'd100, 32'd200);
    push_req(1, 32'd7, 32'd6);
    push_req(2, 32'h1_0000, 32'h1_0000);
    push_req(3, 32'h1_2345, 32'h100);
    drain("all4", 500);

    // Requester 2 reissues back to back while requester 1 waits: order 2,1,2.
    expect_txn(2, 62'd81, 1'b0);
    expect_txn(1, 62'd182, 1'b0);
    expect_txn(2, 62'd132, 1'b0);
    push_req(2, 32'd9, 32'd9);
    push_req(2, 32'd11, 32'd12);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_busy_seen", 128'(busy), 128'(1));
    push_req(1, 32'd13, 32'd14);
    drain("b2b", 400);

    // Withheld finish: watchdog recovery, then normal service.
    withhold = 1'b1;
    expect_txn(3, '0, 1'b1);
    push_req(3, 32'd5, 32'd5);
    drain("timeout", 300);
    withhold = 1'b0;
    check("rst_pulses", 128'(rst_pulses), 128'(1));
    expect_txn(0, 62'd16, 1'b0);
    push_req(0, 32'd4, 32'd4);
    drain("after_timeout", 200);

    // Spurious finish in IDLE then in ISSUE.
    spur_idle_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_idle_busy", 128'(busy), '0);
    end
    spur_issue = 1'b1;
    expect_txn(1, 62'd6, 1'b0);
    push_req(1, 32'd2, 32'd3);
    drain("spur_issue", 200);
    spur_issue = 1'b0;

    // Reset mid-WAIT drops the in-flight transaction and restores priority.
    exp_gnt.push_back(2);
    push_req(2, 32'd6, 32'd7);
    n = 0;
    while (!mul_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_start_seen", 128'(mul_start), 128'(1));
    repeat (3) @(negedge clk);
    check("mid_wait_busy", 128'(busy), 128'(1));
    pulse_reset("reset_mid");
    repeat (LAT + 4) @(negedge clk);
    check("post_reset_idle", 128'({busy, rsp_valid}), '0);
    expect_txn(0, 62'd64, 1'b0);
    expect_txn(3, 62'd100, 1'b0);
    push_req(0, 32'd8, 32'd8);
    push_req(3, 32'd10, 32'd10);
    drain("after_reset", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one sequential 32x32 shift-add multiplier (start/finish handshake, 62-bit result) between NREQ requesters.
- Round-robin arbitration; the block latches the winner's operands, pulses start to the multiplier, and waits for finish. It then returns the result to the winning requester only.
- A watchdog recovers the multiplier if finish never arrives.
- Sits between the requesting FSMs and the single multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, operand width
RW, 62, result width (matches multiplier res)
TIMEOUT, 64, cycles allowed in WAIT before recovery (> multiplier latency of about 35)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request, held until accepted
req_a  in  NREQ*DW  packed multiplicands, slice i = [i*DW +: DW]
req_b  in  NREQ*DW  packed multipliers
req_ready  out  NREQ  one-hot accept pulse; operands sampled this cycle
rsp_valid  out  NREQ  one-hot 1-cycle result pulse to the owning requester
rsp_res  out  RW  result; valid while rsp_valid != 0
rsp_err  out  1  high with rsp_valid when the result came from a timeout (rsp_res = 0)
mul_start  out  1  1-cycle start pulse to multiplier
mul_a  out  DW  latched multiplicand
mul_b  out  DW  latched multiplier
mul_rst  out  1  1-cycle active-high synchronous reset to multiplier (recovery only)
mul_res  in  RW  multiplier result
mul_finish  in  1  multiplier done pulse
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all outputs 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Operand, id, result and watchdog registers = 0.
- States: IDLE, ISSUE, WAIT, RESP, RECOVER.
- IDLE:
  - If any req_valid is set, pick the winner by scanning from ptr+1 upward with wrap.
  - Assert req_ready[winner] combinationally in this same cycle.
  - Latch req_a/req_b slices into mul_a/mul_b, store the winner id, set ptr = winner, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mul_start = 1 for exactly one cycle; watchdog cleared; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - mul_finish = 1: capture mul_res into the result register, err = 0, go to RESP.
  - Watchdog reaches TIMEOUT-1 without finish: go to RECOVER.
  - If finish and timeout occur in the same cycle, finish wins.
- RECOVER: mul_rst = 1 for one cycle; result = 0, err = 1; go to RESP.
- RESP: rsp_valid[id] = 1 for one cycle, with rsp_res and rsp_err driven; go to IDLE.
- rsp_res and rsp_err are 0 outside RESP.
- Minimum turnaround:
  - Accept to next accept = multiplier latency + 3 cycles.
  - No new grant while busy; req_ready stays low outside IDLE.
- mul_finish outside WAIT is ignored; no state change, no capture.
- mul_a/mul_b are held stable from ISSUE through RESP, because the multiplier samples operands in its idle state.
- A requester dropping req_valid before accept is legal and causes no grant. After accept, the transaction completes regardless of req_valid.
- Fairness: a requester that holds req_valid is granted within NREQ arbitration rounds.
- Reset mid-operation: everything returns to the reset values immediately. No rsp_valid is produced for the in-flight transaction. mul_rst is not asserted; the multiplier's own reset is driven by the system reset.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=0, ISSUE=1, WAIT=2, RESP=3, RECOVER=4 (3-bit);
  - default widths DW=32, RW=62;
  - helper constant for the id width, clog2(NREQ).
- One sub-module: rr_picker.
  - Combinational: inputs req vector and ptr; outputs one-hot grant, grant index, and any flag.
  - Reused later by other shared-resource arbiters.

Test Plan:
- Single request: req_valid=0001, a=3, b=5.
  - Expect req_ready=0001 for one cycle, mul_start one cycle later, and rsp_valid=0001 with rsp_res=15, rsp_err=0 one cycle after mul_finish.
- Simultaneous requests: all four asserted after reset.
  - Expect grant order 0,1,2,3,0.
  - Each rsp_valid goes only to its owner, with results a_i*b_i, e.g. 0xFFFFFFFF*2 giving 0x1FFFFFFFE.
- Back-to-back same requester: requester 2 reissues immediately while requester 1 is also waiting.
  - Expect requester 1 granted before requester 2's second request.
- Timeout: the multiplier model withholds finish.
  - Expect mul_rst pulse at WAIT cycle 64, then rsp_valid with rsp_err=1 and rsp_res=0, then return to IDLE and serve the next request normally.
- Spurious finish: mul_finish pulsed in IDLE and ISSUE.
  - Expect no rsp_valid and no state change.
- Async reset mid-WAIT: rst_n dropped for half a cycle.
  - Expect all outputs 0 immediately and no rsp_valid.
  - The next request is granted to requester 0 first.
